// File: rtl/mmuart_pkg.sv
// Shared types and constants for the mmuart receiver (and a future transmitter).
package mmuart_pkg;

    localparam int unsigned DATA_BITS     = 8;
    localparam int unsigned SAMPLE_MID    = 8;
    localparam int unsigned TICKS_PER_BIT = 16;
    localparam int unsigned DIV_W         = 16;
    localparam int unsigned TICK_W        = 4;
    localparam int unsigned BIT_W         = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Registered receive event as seen by the bus side.
    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 done;
        logic                 frame_err;
    } rx_evt_t;

endpackage

// File: rtl/mmuart_rx_if.sv
// Receiver bus: serial line and baud divisor in, received byte and status out.
interface mmuart_rx_if;
    import mmuart_pkg::*;

    logic                 uart_rx;
    logic [DIV_W-1:0]     divisor;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_frame_err;
    logic                 rx_busy;

    modport master (
        output uart_rx, divisor,
        input  rx_data, rx_done, rx_frame_err, rx_busy
    );

    modport slave (
        input  uart_rx, divisor,
        output rx_data, rx_done, rx_frame_err, rx_busy
    );

endinterface

// File: rtl/mmuart_enable16.sv
// 16x oversampling strobe: fires when the down-counter is 0 and reloads divisor-1.
module mmuart_enable16
    import mmuart_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [DIV_W-1:0] divisor,
    output logic             enable16
);

    logic [DIV_W-1:0] r_cnt;

    // divisor=0 wraps the reload to 16'hFFFF, giving a 65536-cycle period.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == '0) begin
            r_cnt <= divisor - DIV_W'(1);
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign enable16 = (r_cnt == '0);

endmodule

// File: rtl/mmuart_rx.sv
// 8N1 UART receiver, 16x oversampled, mid-bit sampling, with framing-error/break handling.
module mmuart_rx
    import mmuart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    mmuart_rx_if.slave  bus
);

    logic                   w_enable16;
    logic                   w_rxs;
    logic [SYNC_STAGES-1:0] r_sync;

    rx_state_e              r_state, w_state_nxt;
    logic [TICK_W-1:0]      r_tick,  w_tick_nxt;
    logic [BIT_W-1:0]       r_bit,   w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    rx_evt_t                r_evt,   w_evt_nxt;
    logic                   r_busy,  w_busy_nxt;

    mmuart_enable16 u_en (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .divisor   (bus.divisor),
        .enable16  (w_enable16)
    );

    // Line synchronizer resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.uart_rx};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_evt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_evt   <= w_evt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Tick counter restarts at the start-bit midpoint, so every later sample lands on a wrap.
    always_comb begin
        w_state_nxt         = r_state;
        w_tick_nxt          = r_tick;
        w_bit_nxt           = r_bit;
        w_shift_nxt         = r_shift;
        w_evt_nxt           = r_evt;
        w_evt_nxt.done      = 1'b0;
        w_evt_nxt.frame_err = 1'b0;

        if (w_enable16) begin
            w_tick_nxt = r_tick + TICK_W'(1);
            case (r_state)
                ST_IDLE: begin
                    w_tick_nxt = '0;
                    if (!w_rxs) begin
                        w_state_nxt = ST_START;
                        w_bit_nxt   = '0;
                    end
                end
                ST_START: begin
                    if (r_tick == TICK_W'(SAMPLE_MID - 1)) begin
                        w_tick_nxt  = '0;
                        w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_tick == TICK_W'(TICKS_PER_BIT - 1)) begin
                        w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        if (r_bit == BIT_W'(DATA_BITS - 1)) begin
                            w_state_nxt = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (r_tick == TICK_W'(TICKS_PER_BIT - 1)) begin
                        if (w_rxs) begin
                            w_evt_nxt.data = r_shift;
                            w_evt_nxt.done = 1'b1;
                            w_state_nxt    = ST_IDLE;
                        end else begin
                            w_evt_nxt.frame_err = 1'b1;
                            w_state_nxt         = ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    w_tick_nxt = '0;
                    if (w_rxs) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign bus.rx_data      = r_evt.data;
    assign bus.rx_done      = r_evt.done;
    assign bus.rx_frame_err = r_evt.frame_err;
    assign bus.rx_busy      = r_busy;

endmodule

// File: tb/tb_mmuart_rx.sv
// Randomized self-checking bench for mmuart_rx against a frame-level event model.
module tb_mmuart_rx;
    import mmuart_pkg::*;

    localparam int unsigned SYNC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mmuart_rx_if bus ();

    mmuart_rx #(.SYNC_STAGES(SYNC)) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Expected event of one frame: kind, byte, and the cycle window its pulse must fall in.
    typedef struct {
        bit         is_err;
        logic [7:0] data;
        longint     lo;
        longint     hi;
    } exp_t;

    exp_t       q[$];
    exp_t       e_cur;
    logic [7:0] model_last = 8'h00;
    logic [7:0] done_hist[$];
    bit         busy_seen  = 1'b0;
    int         n_done     = 0;
    int         n_err      = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Compare process: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_busy) busy_seen = 1'b1;
            if (bus.rx_done || bus.rx_frame_err) begin
                check("pulse_exclusive", longint'(bus.rx_done && bus.rx_frame_err), 0);
                if (q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    e_cur = q.pop_front();
                    check("event_kind_err", longint'(bus.rx_frame_err), longint'(e_cur.is_err));
                    check("event_in_window", longint'(cyc >= e_cur.lo && cyc <= e_cur.hi), 1);
                    if (bus.rx_done) begin
                        n_done++;
                        model_last = e_cur.data;
                        done_hist.push_back(bus.rx_data);
                    end else begin
                        n_err++;
                    end
                end
            end else if (q.size() != 0 && cyc > q[0].hi) begin
                check("missed_event", 0, 1);
                void'(q.pop_front());
            end
            check("rx_data", longint'(bus.rx_data), longint'(model_last));
        end
    end

    task automatic hold(input logic v, input int n);
        bus.uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame at 16*d clocks per bit; the model expects the stop sample 152 ticks in.
    task automatic send(input logic [7:0] b, input logic stop, input int d, input bit expect_evt);
        exp_t e;
        e.is_err = !stop;
        e.data   = b;
        e.lo     = cyc + longint'(152 * d);
        e.hi     = cyc + longint'(152 * d + d + int'(SYNC) + 3);
        if (expect_evt) q.push_back(e);
        hold(1'b0, 16 * d);
        for (int i = 0; i < 8; i++) hold(b[i], 16 * d);
        hold(stop, 16 * d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        model_last = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        int         d;
        int         n_before;
        logic [7:0] b;
        logic       stop;
        longint     c0;
        int         guard;
        int         ones;

        bus.uart_rx = 1'b1;
        bus.divisor = 16'd1;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_data", longint'(bus.rx_data), 0);
        check("rst_rx_done", longint'(bus.rx_done), 0);
        check("rst_rx_frame_err", longint'(bus.rx_frame_err), 0);
        check("rst_rx_busy", longint'(bus.rx_busy), 0);
        rst_n = 1'b1;
        hold(1'b1, 5);

        // Single byte at 16 clocks per bit.
        send(8'hA5, 1'b1, 1, 1'b1);
        hold(1'b1, 4);
        check("a5_data", longint'(bus.rx_data), 64'hA5);
        check("a5_done_count", n_done, 1);
        check("a5_busy_after", longint'(bus.rx_busy), 0);

        // Short low glitch must be rejected at the start-bit midpoint.
        busy_seen = 1'b0;
        hold(1'b0, 5);
        hold(1'b1, 40);
        check("glitch_busy_seen", longint'(busy_seen), 1);
        check("glitch_busy_after", longint'(bus.rx_busy), 0);
        check("glitch_no_done", n_done, 1);
        check("glitch_no_err", n_err, 0);

        // Framing error followed by a long break, then recovery.
        send(8'h3C, 1'b0, 1, 1'b1);
        hold(1'b0, 40 * 16);
        check("break_busy", longint'(bus.rx_busy), 1);
        check("ferr_count", n_err, 1);
        check("ferr_data_kept", longint'(bus.rx_data), 64'hA5);
        hold(1'b1, 48);
        check("break_exit_busy", longint'(bus.rx_busy), 0);
        send(8'h00, 1'b1, 1, 1'b1);
        hold(1'b1, 4);
        check("zero_data", longint'(bus.rx_data), 0);
        check("zero_done_count", n_done, 2);

        // Back-to-back frames at divisor 3.
        bus.divisor = 16'd3;
        hold(1'b1, 10);
        send(8'h55, 1'b1, 3, 1'b1);
        send(8'hAA, 1'b1, 3, 1'b1);
        hold(1'b1, 8);
        check("b2b_done_count", n_done, 4);
        check("b2b_first_byte", longint'(done_hist[2]), 64'h55);
        check("b2b_second_byte", longint'(bus.rx_data), 64'hAA);

        // Randomized frames, divisors, gaps, stop bits and glitches.
        for (int k = 0; k < 12; k++) begin
            d           = int'($urandom_range(1, 4));
            bus.divisor = 16'(d);
            hold(1'b1, 10 + int'($urandom_range(0, 20)));
            if ($urandom_range(0, 3) == 0) begin
                hold(1'b0, int'($urandom_range(1, 6 * d)));
                hold(1'b1, 16 * d);
            end
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send(b, stop, d, 1'b1);
            if (!stop) hold(1'b1, 32 * d);
        end
        hold(1'b1, 20);
        check("random_queue_drained", q.size(), 0);

        // Reset during bit 4 of 0xFF discards the frame.
        bus.divisor = 16'd1;
        hold(1'b1, 10);
        hold(1'b0, 16);
        for (int i = 0; i < 4; i++) hold(1'b1, 16);
        hold(1'b1, 8);
        do_reset();
        check("midrst_rx_data", longint'(bus.rx_data), 0);
        check("midrst_busy", longint'(bus.rx_busy), 0);
        hold(1'b1, 3);
        rst_n = 1'b1;
        hold(1'b1, 20);
        check("midrst_no_pulse", q.size(), 0);
        n_before = n_done;
        send(8'h81, 1'b1, 1, 1'b1);
        hold(1'b1, 4);
        check("after_rst_data", longint'(bus.rx_data), 64'h81);
        check("after_rst_done_count", n_done, n_before + 1);

        // divisor=0 gives a 65536-cycle strobe period.
        bus.divisor = 16'd0;
        do_reset();
        rst_n = 1'b1;
        guard = 0;
        while (!u_dut.u_en.enable16 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        c0    = cyc;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!u_dut.u_en.enable16 && guard < 70000);
        check("div0_period", cyc - c0, 65536);

        // divisor=1 strobes every cycle.
        bus.divisor = 16'd1;
        do_reset();
        rst_n = 1'b1;
        @(negedge clk);
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            if (u_dut.u_en.enable16) ones++;
            @(negedge clk);
        end
        check("div1_every_cycle", ones, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmuart_rx.md
MMUART_RX -- requirements
Module: mmuart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of uart_rx synchronizer flops (minimum 2).
REQ-002 SHALL have port sys_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port divisor  input  16  sys_clk cycles per 1/16 bit period; sampled at each reload.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte.
REQ-007 SHALL have port rx_done  output  1  one-cycle pulse when rx_data is updated.
REQ-008 SHALL have port rx_frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port rx_busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL contain a 16-bit down-counter that asserts enable16 when at 0 and reloads divisor-1 on that cycle, otherwise decrements.
REQ-011 SHALL, for divisor=0, wrap divisor-1 to 16'hFFFF (65536-cycle period); divisor=1 SHALL give enable16 every cycle.
REQ-012 SHALL pass uart_rx through SYNC_STAGES flops; all decisions SHALL use the synchronized value (rxs).
REQ-013 SHALL advance the FSM and 4-bit tick counter only on cycles where enable16 is high.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: a tick with rxs=0 is tick 0 -> START, tick counter cleared.
REQ-016 START: at tick 8, rxs=1 -> IDLE (glitch rejected, no output pulse); rxs=0 -> DATA.
REQ-017 DATA: data bit i (i=0..7) SHALL be sampled at tick 8+16*(i+1) and shifted in LSB first; after bit 7 -> STOP.
REQ-018 STOP: sample at tick 152; rxs=1 -> load rx_data, pulse rx_done, -> IDLE; rxs=0 -> pulse rx_frame_err, rx_data unchanged, -> BREAK.
REQ-019 BREAK: remain until a tick with rxs=1, then -> IDLE; no start detection while in BREAK.
REQ-020 rx_done and rx_frame_err SHALL be registered, high exactly the cycle after the tick-152 enable16 cycle, and never both high.
REQ-021 A start bit immediately following a valid stop sample SHALL be accepted (back-to-back frames, zero idle).
REQ-022 A change of divisor mid-frame SHALL take effect at the next counter reload only; no other recovery required.

Reset
REQ-023 Asserting sys_rst_n low SHALL immediately force: state IDLE, tick and bit counters 0, enable16 counter 0, synchronizer flops 1, shift register 0.
REQ-024 Output reset values SHALL be rx_data=8'h00, rx_done=0, rx_frame_err=0, rx_busy=0.
REQ-025 Reset mid-frame SHALL discard the partial byte with no pulse; reception restarts at the first tick with rxs=0 after release.

Structure
REQ-026 Package mmuart_pkg SHALL hold the state enum, DATA_BITS=8, SAMPLE_MID=8 and TICKS_PER_BIT=16.
REQ-027 The enable16 generator SHALL be the sub-module mmuart_enable16 (ports sys_clk, sys_rst_n, divisor, enable16), reusable by a future transmitter.

Verification
REQ-028 divisor=1 (16 clk/bit), send 0xA5 -> rx_data=8'hA5, exactly one rx_done pulse about 152+SYNC_STAGES+1 clocks after the start edge, rx_busy low afterwards.
REQ-029 divisor=1, uart_rx low for 5 clocks then high -> rx_busy pulses, no rx_done, no rx_frame_err, FSM returns to IDLE.
REQ-030 After 0xA5, send 0x3C with stop bit 0 and hold the line low for 40 bit times -> one rx_frame_err, rx_data stays 8'hA5, no further events; line high, then 0x00 -> rx_done, rx_data=8'h00.
REQ-031 divisor=3, frames 0x55 then 0xAA with zero idle -> two rx_done pulses, rx_data 8'h55 then 8'hAA.
REQ-032 Assert sys_rst_n low during bit 4 of 0xFF, release, send 0x81 -> no pulse for the aborted frame, then rx_data=8'h81.
REQ-033 divisor=0 -> enable16 period measured as 65536 clocks; divisor=1 -> enable16 high every cycle.
